// File: rtl/ram_op_sequencer_pkg.sv
// Shared definitions for the RAM operand sequencer: state encoding and ALU opcodes.
package ram_op_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/ram_op_sequencer_if.sv
// Instruction handshake plus RAM port A/B/C bus for the sequencer.
// FLAG_Z/FLAG_C exist only when RAM_OP_SEQUENCER_FLAGS_EN is defined.
interface ram_op_sequencer_if
    import ram_op_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [OP_W-1:0]   IN_OP;
    logic [ADDR_W-1:0] IN_SRC_A;
    logic [ADDR_W-1:0] IN_SRC_B;
    logic [ADDR_W-1:0] IN_DST;
    logic [ADDR_W-1:0] Addr_A;
    logic [DATA_W-1:0] Data_A;
    logic [ADDR_W-1:0] Addr_B;
    logic [DATA_W-1:0] Data_B;
    logic [ADDR_W-1:0] Addr_C;
    logic [DATA_W-1:0] Data_C;
    logic              WE_C;
    logic              DONE;
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
    logic              FLAG_Z;
    logic              FLAG_C;
`endif

    // Sequencer side
    modport slave (
        input  IN_VALID, IN_OP, IN_SRC_A, IN_SRC_B, IN_DST, Data_A, Data_B,
        output IN_READY, Addr_A, Addr_B, Addr_C, Data_C, WE_C, DONE
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
        , FLAG_Z, FLAG_C
`endif
    );

    // Instruction source / RAM side
    modport master (
        output IN_VALID, IN_OP, IN_SRC_A, IN_SRC_B, IN_DST, Data_A, Data_B,
        input  IN_READY, Addr_A, Addr_B, Addr_C, Data_C, WE_C, DONE
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
        , FLAG_Z, FLAG_C
`endif
    );

endinterface

// File: rtl/ram_op_sequencer_alu.sv
// Combinational 8-op ALU; the carry output exists only with RAM_OP_SEQUENCER_FLAGS_EN.
module ram_op_alu
    import ram_op_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
    ,
    output logic              carry
`endif
);

`ifdef RAM_OP_SEQUENCER_FLAGS_EN
    // Extra top bit carries add carry-out, subtract borrow, or the shifted-out bit
    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
            OP_XOR: wide = {1'b0, a ^ b};
            OP_NOT: wide = {1'b0, ~a};
            OP_SHL: wide = {a, 1'b0};
            OP_SHR: wide = {a[0], 1'b0, a[DATA_W-1:1]};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];
`else
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: result = {a[DATA_W-2:0], 1'b0};
            OP_SHR: result = {1'b0, a[DATA_W-1:1]};
        endcase
    end
`endif

endmodule

// File: rtl/ram_op_sequencer.sv
// Non-pipelined read/exec/write controller for the dual-port operand RAM.
// Optional FLAG_Z/FLAG_C outputs: define RAM_OP_SEQUENCER_FLAGS_EN.
module ram_op_sequencer
    import ram_op_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    ram_op_sequencer_if.slave bus
);

    logic [1:0]        state;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] z_q;
    logic [DATA_W-1:0] alu_result;
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
    logic              alu_carry;
    logic              flag_z_q;
    logic              flag_c_q;
`endif

    ram_op_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (bus.Data_A),
        .b      (bus.Data_B),
        .result (alu_result)
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
        ,
        .carry  (alu_carry)
`endif
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            z_q     <= '0;
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.IN_VALID) begin
                        op_q    <= bus.IN_OP;
                        src_a_q <= bus.IN_SRC_A;
                        src_b_q <= bus.IN_SRC_B;
                        dst_q   <= bus.IN_DST;
                        state   <= ST_READ;
                    end
                end
                ST_READ: state <= ST_EXEC;
                ST_EXEC: begin
                    z_q   <= alu_result;
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
                    flag_z_q <= (alu_result == '0);
                    flag_c_q <= alu_carry;
`endif
                    state <= ST_WRITE;
                end
                ST_WRITE: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign bus.IN_READY = (state == ST_IDLE);
    assign bus.WE_C     = (state == ST_WRITE);
    assign bus.DONE     = (state == ST_WRITE);
    assign bus.Addr_A   = src_a_q;
    assign bus.Addr_B   = src_b_q;
    assign bus.Addr_C   = dst_q;
    assign bus.Data_C   = z_q;
`ifdef RAM_OP_SEQUENCER_FLAGS_EN
    assign bus.FLAG_Z   = flag_z_q;
    assign bus.FLAG_C   = flag_c_q;
`endif

endmodule
